mask_window_3x3: RTL and testbench

- Generates the 3x3 neighbourhood window consumed by the red-pixel mask filter stage.
- Accepts a 1-bit mask AXI-Stream (tdata/tuser/tlast) and buffers two full lines plus a 3-tap shift per row.
- Emits one window per accepted pixel once primed: three 9-bit rows of packed 3-bit pixels {data,tuser,tlast}, zero-padded at the image borders.
- Sits between the upstream colour-threshold stage and the filter, and drives the filter's window valid/ready inputs.

---
 rtl/mask_window_3x3_pkg.sv | 17 +
 rtl/line_delay_fifo.sv | 42 ++++
 rtl/mask_window_3x3.sv | 112 +++++++++++
 tb/tb_mask_window_3x3.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mask_window_3x3_pkg.sv
// Pixel packing and window row layout shared by the 3x3 window generator and the mask filter.
package mask_window_3x3_pkg;

  localparam int PIX_W     = 3;
  localparam int PIX_DATA  = 2;
  localparam int PIX_USER  = 1;
  localparam int PIX_LAST  = 0;

  // Field index inside a packed row: L occupies [8:6], C [5:3], R [2:0].
  localparam int FLD_L     = 2;
  localparam int FLD_C     = 1;
  localparam int FLD_R     = 0;
  localparam int WIN_ROW_W = 3 * PIX_W;

  typedef logic [PIX_W-1:0] pix_t;

endpackage

// File: rtl/line_delay_fifo.sv
// Fixed-length delay line: o_data is the word written DEPTH enables ago (read-before-write).
// Advances only when i_en is high; RAM contents are never reset.
module line_delay_fifo
  import mask_window_3x3_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int WIDTH = PIX_W
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    ptr_q;
  logic [AW-1:0]    ptr_d;

  assign o_data = mem_q[ptr_q];

  always_comb begin
    ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      ptr_q <= '0;
    end else if (i_en) begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      mem_q[ptr_q] <= i_data;
    end
  end

endmodule

// File: rtl/mask_window_3x3.sv
// 3x3 neighbourhood window generator: window for pixel n appears one cycle after accepting pixel n+IMG_WIDTH+1.
// 1-deep register slice: input stalls only while a window is held and downstream is not ready.
module mask_window_3x3
  import mask_window_3x3_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COL_W      = $clog2(IMG_WIDTH),
  parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_tdata,
  input  logic                 i_tuser,
  input  logic                 i_tlast,
  input  logic                 i_tvalid,
  output logic                 o_tready,
  output logic [WIN_ROW_W-1:0] o_r0_data,
  output logic [WIN_ROW_W-1:0] o_r1_data,
  output logic [WIN_ROW_W-1:0] o_r2_data,
  output logic                 o_tvalid,
  input  logic                 i_tready
);

  localparam int PRIME_MAX = IMG_WIDTH + 1;
  localparam int PRIME_W   = $clog2(IMG_WIDTH + 2);

  logic [2:0][2:0][PIX_W-1:0] tap_q, tap_d;
  logic [2:0][2:0][PIX_W-1:0] win_q, win_d;
  logic [2:0][PIX_W-1:0]      row_in;
  logic [PRIME_W-1:0]         prime_q;
  logic [COL_W-1:0]           col_q, col_d, cur_col;
  logic [ROW_W-1:0]           row_q, row_d, cur_row;
  logic                       tvalid_q;
  pix_t                       pix, lb1_out, lb0_out, center;
  logic                       accept, xfer_out, primed, load, pad_l, pad_r;

  assign pix      = {i_tdata, i_tuser, i_tlast};
  assign o_tready = i_tready || !tvalid_q;
  assign accept   = i_tvalid && o_tready;
  assign xfer_out = tvalid_q && i_tready;
  assign primed   = (prime_q == PRIME_W'(PRIME_MAX));
  assign load     = accept && primed;

  line_delay_fifo #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb1 (
    .i_clk (i_clk), .i_rstn(i_rstn), .i_en(accept), .i_data(pix),     .o_data(lb1_out)
  );
  line_delay_fifo #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb0 (
    .i_clk (i_clk), .i_rstn(i_rstn), .i_en(accept), .i_data(lb1_out), .o_data(lb0_out)
  );

  // The window is built from the post-shift taps so the newest pixel lands in R this cycle.
  always_comb begin
    row_in = {pix, lb1_out, lb0_out};
    tap_d  = tap_q;
    for (int r = 0; r < 3; r++) begin
      tap_d[r][FLD_L] = tap_q[r][FLD_C];
      tap_d[r][FLD_C] = tap_q[r][FLD_R];
      tap_d[r][FLD_R] = row_in[r];
    end
    center  = tap_d[1][FLD_C];
    cur_col = center[PIX_USER] ? '0 : col_q;
    cur_row = center[PIX_USER] ? '0 : row_q;
    pad_l   = (cur_col == '0);
    pad_r   = (cur_col == COL_W'(IMG_WIDTH - 1)) || center[PIX_LAST];

    win_d = tap_d;
    for (int r = 0; r < 3; r++) begin
      if (pad_l) win_d[r][FLD_L] = '0;
      if (pad_r) win_d[r][FLD_R] = '0;
    end
    if (cur_row == '0) win_d[0] = '0;
    if (cur_row == ROW_W'(IMG_HEIGHT - 1)) win_d[2] = '0;

    col_d = cur_col + 1'b1;
    row_d = cur_row;
    if (pad_r) begin
      col_d = '0;
      row_d = (cur_row == ROW_W'(IMG_HEIGHT - 1)) ? '0 : cur_row + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      tap_q    <= '0;
      win_q    <= '0;
      prime_q  <= '0;
      col_q    <= '0;
      row_q    <= '0;
      tvalid_q <= 1'b0;
    end else begin
      if (accept) begin
        tap_q <= tap_d;
        if (!primed) prime_q <= prime_q + 1'b1;
      end
      if (load) begin
        win_q    <= win_d;
        tvalid_q <= 1'b1;
        col_q    <= col_d;
        row_q    <= row_d;
      end else if (xfer_out) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign o_r0_data = win_q[0];
  assign o_r1_data = win_q[1];
  assign o_r2_data = win_q[2];
  assign o_tvalid  = tvalid_q;

endmodule

// File: tb/tb_mask_window_3x3.sv
// Directed bench for mask_window_3x3 with a 4x3 image; windows are logged on every output transfer.
module tb_mask_window_3x3;

  localparam int W = 4;
  localparam int H = 3;

  logic       i_clk = 1'b0;
  logic       i_rstn, i_tdata, i_tuser, i_tlast, i_tvalid, i_tready;
  logic       o_tready, o_tvalid;
  logic [8:0] o_r0_data, o_r1_data, o_r2_data;

  int          checks = 0;
  int          failures = 0;
  int          win_base = 0;
  logic [26:0] win_log[$];
  logic [2:0]  stream_q[$];
  bit          rand_mode = 1'b0;

  mask_window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_tdata  (i_tdata),
    .i_tuser  (i_tuser),
    .i_tlast  (i_tlast),
    .i_tvalid (i_tvalid),
    .o_tready (o_tready),
    .o_r0_data(o_r0_data),
    .o_r1_data(o_r1_data),
    .o_r2_data(o_r2_data),
    .o_tvalid (o_tvalid),
    .i_tready (i_tready)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (i_rstn && o_tvalid && i_tready) win_log.push_back({o_r0_data, o_r1_data, o_r2_data});
  end

  function automatic logic [2:0] allones_pix(input int idx);
    return {1'b1, (idx % (W * H)) == 0, (idx % W) == W - 1};
  endfunction

  function automatic logic [2:0] checker_pix(input int idx);
    int c, r;
    c = idx % W;
    r = (idx / W) % H;
    return {((r + c) % 2) == 1, (idx % (W * H)) == 0, c == W - 1};
  endfunction

  // Reference window: neighbours looked up directly in the accepted stream, outside the image -> 0.
  function automatic logic [26:0] model_win(input int k);
    int col, row, rr, cc;
    logic [26:0] w;
    col = k % W;
    row = (k / W) % H;
    w = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = row + dr;
        cc = col + dc;
        if (rr >= 0 && rr < H && cc >= 0 && cc < W)
          w[26 - ((dr + 1) * 9 + (dc + 1) * 3) -: 3] = stream_q[k + dr * W + dc];
      end
    end
    return w;
  endfunction

  task automatic reset_dut();
    i_tvalid = 1'b0;
    i_tready = 1'b1;
    i_rstn   = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rstn   = 1'b1;
    stream_q.delete();
    win_base = win_log.size();
  endtask

  task automatic send(input logic [2:0] p);
    int guard;
    guard = 0;
    i_tvalid = 1'b1;
    {i_tdata, i_tuser, i_tlast} = p;
    forever begin
      @(negedge i_clk);
      if (o_tready) break;
      guard++;
      if (guard > 200) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: o_tready=%0b after %0d cycles, required 1", o_tready, guard);
        break;
      end
      @(posedge i_clk);
      #1;
      if (rand_mode) i_tready = 1'($urandom_range(0, 1));
    end
    @(posedge i_clk);
    #1;
    stream_q.push_back(p);
    if (rand_mode) i_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_allones_until(input int n);
    while (stream_q.size() < n) send(allones_pix(stream_q.size()));
  endtask

  task automatic test_reset();
    reset_dut();
    checks++; if (o_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid: got %b want 0", o_tvalid); end
    checks++; if (o_r0_data !== 9'd0) begin failures++; $display("FAIL rst_r0: got %b want 0", o_r0_data); end
    checks++; if (o_r1_data !== 9'd0) begin failures++; $display("FAIL rst_r1: got %b want 0", o_r1_data); end
    checks++; if (o_r2_data !== 9'd0) begin failures++; $display("FAIL rst_r2: got %b want 0", o_r2_data); end
    i_tready = 1'b0;
    #1;
    checks++; if (o_tready !== 1'b1) begin failures++; $display("FAIL rst_tready: got %b want 1", o_tready); end
    i_tready = 1'b1;
  endtask

  task automatic test_first_window();
    send_allones_until(5);
    checks++; if (o_tvalid !== 1'b0) begin failures++; $display("FAIL prime_5: o_tvalid got %b want 0", o_tvalid); end
    send_allones_until(6);
    checks++; if (o_tvalid !== 1'b1) begin failures++; $display("FAIL first_tvalid: got %b want 1", o_tvalid); end
    checks++; if (o_r0_data !== 9'b000_000_000) begin failures++; $display("FAIL first_r0: got %b want 000000000", o_r0_data); end
    checks++; if (o_r1_data !== 9'b000_110_100) begin failures++; $display("FAIL first_r1: got %b want 000110100", o_r1_data); end
    checks++; if (o_r2_data !== 9'b000_100_100) begin failures++; $display("FAIL first_r2: got %b want 000100100", o_r2_data); end
  endtask

  task automatic test_right_border();
    send_allones_until(13);  // center (3,1)
    checks++; if (o_r0_data !== 9'b100_101_000) begin failures++; $display("FAIL rb_r0: got %b want 100101000", o_r0_data); end
    checks++; if (o_r1_data !== 9'b100_101_000) begin failures++; $display("FAIL rb_r1: got %b want 100101000", o_r1_data); end
    checks++; if (o_r2_data !== 9'b100_101_000) begin failures++; $display("FAIL rb_r2: got %b want 100101000", o_r2_data); end
  endtask

  task automatic test_bottom_row();
    send_allones_until(15);  // center (1,2)
    checks++; if (o_r0_data !== 9'b100_100_100) begin failures++; $display("FAIL bot1_r0: got %b want 100100100", o_r0_data); end
    checks++; if (o_r1_data !== 9'b100_100_100) begin failures++; $display("FAIL bot1_r1: got %b want 100100100", o_r1_data); end
    checks++; if (o_r2_data !== 9'b000_000_000) begin failures++; $display("FAIL bot1_r2: got %b want 0", o_r2_data); end
    send_allones_until(16);  // center (2,2): R neighbours are the tlast pixels
    checks++; if (o_r0_data !== 9'b100_100_101) begin failures++; $display("FAIL bot2_r0: got %b want 100100101", o_r0_data); end
    checks++; if (o_r1_data !== 9'b100_100_101) begin failures++; $display("FAIL bot2_r1: got %b want 100100101", o_r1_data); end
    checks++; if (o_r2_data !== 9'b000_000_000) begin failures++; $display("FAIL bot2_r2: got %b want 0", o_r2_data); end
  endtask

  task automatic test_backpressure();
    logic [26:0] snap;
    send_allones_until(17);
    snap = {o_r0_data, o_r1_data, o_r2_data};
    i_tready = 1'b0;
    i_tvalid = 1'b1;
    {i_tdata, i_tuser, i_tlast} = allones_pix(17);
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      checks++; if (o_tready !== 1'b0) begin failures++; $display("FAIL stall_tready[%0d]: got %b want 0", i, o_tready); end
      checks++;
      if ({o_tvalid, o_r0_data, o_r1_data, o_r2_data} !== {1'b1, snap}) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got %b/%h want 1/%h", i, o_tvalid, {o_r0_data, o_r1_data, o_r2_data}, snap);
      end
    end
    @(posedge i_clk);
    #1;
    i_tready = 1'b1;
    send_allones_until(29);
    i_tvalid = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if (win_log.size() - win_base !== 24) begin
      failures++;
      $display("FAIL bp_count: got %0d windows want 24", win_log.size() - win_base);
    end
    for (int k = 0; k < 24 && win_base + k < win_log.size(); k++) begin
      checks++;
      if (win_log[win_base + k] !== model_win(k)) begin
        failures++;
        $display("FAIL bp_win[%0d]: got %h want %h", k, win_log[win_base + k], model_win(k));
      end
    end
  endtask

  task automatic test_reset_midframe();
    reset_dut();
    send_allones_until(7);
    reset_dut();
    checks++; if (o_tvalid !== 1'b0) begin failures++; $display("FAIL mid_rst_tvalid: got %b want 0", o_tvalid); end
    send_allones_until(5);
    checks++; if (o_tvalid !== 1'b0) begin failures++; $display("FAIL mid_prime: o_tvalid got %b want 0", o_tvalid); end
    send_allones_until(6);
    checks++; if (o_tvalid !== 1'b1) begin failures++; $display("FAIL mid_tvalid: got %b want 1", o_tvalid); end
    checks++;
    if ({o_r0_data, o_r1_data, o_r2_data} !== {9'b000_000_000, 9'b000_110_100, 9'b000_100_100}) begin
      failures++;
      $display("FAIL mid_win: got %b_%b_%b want 000000000_000110100_000100100", o_r0_data, o_r1_data, o_r2_data);
    end
  endtask

  task automatic test_bubbles();
    int gap;
    reset_dut();
    rand_mode = 1'b1;
    for (int i = 0; i < 2 * W * H; i++) begin
      gap = $urandom_range(0, 2);
      if (gap > 0) i_tvalid = 1'b0;
      repeat (gap) begin
        @(posedge i_clk);
        #1;
        i_tready = 1'($urandom_range(0, 1));
      end
      send(checker_pix(i));
    end
    rand_mode = 1'b0;
    i_tvalid  = 1'b0;
    i_tready  = 1'b1;
    repeat (4) @(posedge i_clk);
    #1;
    checks++;
    if (win_log.size() - win_base !== 19) begin
      failures++;
      $display("FAIL bub_count: got %0d windows want 19", win_log.size() - win_base);
    end
    for (int k = 0; k < 19 && win_base + k < win_log.size(); k++) begin
      checks++;
      if (win_log[win_base + k] !== model_win(k)) begin
        failures++;
        $display("FAIL bub_win[%0d]: got %h want %h", k, win_log[win_base + k], model_win(k));
      end
    end
  endtask

  initial begin
    i_rstn   = 1'b0;
    i_tvalid = 1'b0;
    i_tready = 1'b1;
    i_tdata  = 1'b0;
    i_tuser  = 1'b0;
    i_tlast  = 1'b0;
    test_reset();
    test_first_window();
    test_right_border();
    test_bottom_row();
    test_backpressure();
    test_reset_midframe();
    test_bubbles();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
